// File: rtl/mul_div_unit_if.sv
// Start/valid handshake bundle between the EX stage and the multiply/divide unit.
interface mul_div_unit_if #(
  parameter int DATA_W = 32
);
  logic                start_i;
  logic [1:0]          op_i;
  logic [DATA_W-1:0]   a_i;
  logic [DATA_W-1:0]   b_i;
  logic                annul_i;
  logic                busy_o;
  logic                valid_o;
  logic [2*DATA_W-1:0] result_o;
  logic                div_by_zero_o;

  modport master (
    output start_i, op_i, a_i, b_i, annul_i,
    input  busy_o, valid_o, result_o, div_by_zero_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, annul_i,
    output busy_o, valid_o, result_o, div_by_zero_o
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle signed/unsigned multiply/divide unit returning {hi,lo} for the HI/LO pair.
// Define MDU_EARLY_OUT_EN to complete divides with |a| < |b| one cycle after accept.
module mul_div_unit #(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_div_unit_if.slave bus
);
  localparam int MAX_CYC = (DATA_W > MUL_CYCLES) ? DATA_W : MUL_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   mag_a, mag_b, quo, rem;
  logic                neg_q, neg_r;
  logic                valid_q, dbz_q;
  logic [2*DATA_W-1:0] result_q;

  logic                accept, is_div, is_signed, sign_a, sign_b;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [DATA_W:0]     shifted;
  logic [DATA_W-1:0]   diff, rem_nxt, quo_nxt, fix_rem, fix_quo;
  logic                fits;
  logic [2*DATA_W-1:0] prod_mag, prod;

  // Signed ops work on magnitudes; the sign bits are kept for the final fix-up.
  assign accept    = bus.start_i && !bus.annul_i && (state == IDLE || state == DONE);
  assign is_div    = bus.op_i[1];
  assign is_signed = !bus.op_i[0];
  assign sign_a    = is_signed & bus.a_i[DATA_W-1];
  assign sign_b    = is_signed & bus.b_i[DATA_W-1];
  assign abs_a     = sign_a ? -bus.a_i : bus.a_i;
  assign abs_b     = sign_b ? -bus.b_i : bus.b_i;

  // One restoring step: the partial remainder always stays below the divisor.
  assign shifted = {rem, quo[DATA_W-1]};
  assign fits    = shifted >= {1'b0, mag_b};
  assign diff    = shifted[DATA_W-1:0] - mag_b;
  assign rem_nxt = fits ? diff : shifted[DATA_W-1:0];
  assign quo_nxt = {quo[DATA_W-2:0], fits};
  assign fix_quo = neg_q ? -quo_nxt : quo_nxt;
  assign fix_rem = neg_r ? -rem_nxt : rem_nxt;

  assign prod_mag = {{DATA_W{1'b0}}, mag_a} * {{DATA_W{1'b0}}, mag_b};
  assign prod     = neg_q ? -prod_mag : prod_mag;

  assign bus.busy_o        = (state == MUL) || (state == DIV);
  assign bus.valid_o       = valid_q;
  assign bus.div_by_zero_o = dbz_q;
  assign bus.result_o      = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      quo      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      valid_q  <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            mag_a <= abs_a;
            mag_b <= abs_b;
            neg_q <= sign_a ^ sign_b;
            neg_r <= sign_a;
            quo   <= abs_a;
            rem   <= '0;
            cnt   <= '0;
            if (!is_div) begin
              state <= MUL;
            end else if (bus.b_i == '0) begin
              state    <= DONE;
              result_q <= {bus.a_i, {DATA_W{1'b1}}};
              valid_q  <= 1'b1;
              dbz_q    <= 1'b1;
`ifdef MDU_EARLY_OUT_EN
            end else if (abs_a < abs_b) begin
              // Quotient is zero and the remainder is the dividend itself, sign included.
              state    <= DONE;
              result_q <= {bus.a_i, {DATA_W{1'b0}}};
              valid_q  <= 1'b1;
`endif
            end else begin
              state <= DIV;
            end
          end else begin
            state <= IDLE;
          end
        end
        MUL: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else if (cnt == CNT_W'(MUL_CYCLES - 1)) begin
            state    <= DONE;
            result_q <= prod;
            valid_q  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DATA_W - 1)) begin
              state    <= DONE;
              result_q <= {fix_rem, fix_quo};
              valid_q  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the EX stage.
- Handles signed and unsigned multiply and divide under one start/valid handshake.
- Returns a 2*DATA_W {hi,lo} result for the HI/LO register pair.
- Differs from the previous divider:
  - generic operand width;
  - configurable multiply latency;
  - annul and back-to-back starts;
  - divide-by-zero flag.

Parameters:
DATA_W, 32, operand width in bits (>=4)
MUL_CYCLES, 2, cycles spent in MUL state before result (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
start_i  in  1  request; sampled only in IDLE or DONE
op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a_i  in  DATA_W  dividend / multiplicand
b_i  in  DATA_W  divisor / multiplier
annul_i  in  1  abort current operation
busy_o  out  1  high in MUL or DIV state
valid_o  out  1  one-cycle pulse, result_o updated
result_o  out  2*DATA_W  {hi,lo}: product, or {remainder,quotient}
div_by_zero_o  out  1  qualifies valid_o; divide with b=0

Behaviour:
- Reset (rst=0, any time, including mid-operation):
  - state IDLE;
  - busy_o, valid_o, div_by_zero_o = 0;
  - result_o = 0;
  - counters cleared.
- States: IDLE, MUL, DIV, DONE.
- Accept:
  - When start_i=1 and annul_i=0 in IDLE or DONE, latch op, a_i and b_i.
  - Sign handling: signed ops latch absolute values plus the sign bits; unsigned ops latch raw values.
- Next state after accept:
  - MULT/MULTU -> MUL.
  - DIV/DIVU with b=0 -> DONE.
  - Other DIV/DIVU -> DIV.
- MUL:
  - Counter runs MUL_CYCLES cycles, then -> DONE.
  - Product is the 2*DATA_W unsigned product of the magnitudes, two's-complement negated if signed and sign(a)^sign(b).
- DIV:
  - Restoring radix-2, one quotient bit per cycle, exactly DATA_W cycles, then -> DONE.
  - Signed fix-up on DONE entry: quotient negated if sign(a)^sign(b); remainder takes sign of a.
  - MIN/-1 yields quotient = MIN (0x80000000 at 32 bits), remainder = 0; no trap.
- Divide by zero: hi = a_i as latched (raw), lo = all ones, div_by_zero_o = 1 in DONE.
- DONE:
  - valid_o = 1 for exactly one cycle; result_o registered on DONE entry.
  - Next state: new accept (back-to-back), otherwise IDLE.
- Latency from accept edge to valid_o high:
  - multiply: MUL_CYCLES+1 cycles;
  - divide: DATA_W+1 cycles;
  - divide by zero: 1 cycle.
- busy_o: high in MUL and DIV; low in IDLE and DONE.
- result_o holds its last value until the next DONE entry.
- div_by_zero_o is low except in a DONE caused by b=0.
- annul_i:
  - In MUL or DIV: next state IDLE, no valid_o, result_o unchanged.
  - In IDLE or DONE together with start_i: start is ignored.
  - annul_i has priority over completion in the same cycle.
- start_i while busy_o=1 is ignored; no queuing.
- Operand inputs may change freely after accept.

Optional Feature:
MDU_EARLY_OUT_EN
- Defined: an unsigned divide (magnitudes) with |a| < |b| goes directly to DONE.
  - Result: quotient 0, remainder = a with signed fix-up.
  - valid_o 1 cycle after accept.
- Undefined: all non-zero-divisor divides take the fixed DATA_W+1 latency.

Test Plan (DATA_W=32, MUL_CYCLES=2):
- MULT a=0xFFFFFFFE, b=3 -> result_o=0xFFFFFFFF_FFFFFFFA, valid_o 3 cycles after accept. MULTU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE_00000001.
- Signed and unsigned divides:
  - DIV -7/2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD, valid_o 33 cycles after accept.
  - DIVU 100/7 -> hi=2, lo=14.
  - DIV 0x80000000/0xFFFFFFFF -> hi=0, lo=0x80000000.
- DIVU 5/0 -> valid_o and div_by_zero_o 1 cycle after accept; hi=5, lo=0xFFFFFFFF.
- Annul mid-divide:
  - Stimulus: prior result 0x1_00000002; DIV started; annul_i pulsed in the 10th DIV cycle.
  - Response: busy_o low next cycle; no valid_o; result_o stays 0x1_00000002; a fresh MULTU 3*4 then returns 12.
- Back-to-back: start_i held with a new MULTU 2*5 in the DONE cycle of a previous op -> accepted, valid_o 3 cycles later, result 10. start_i pulsed while busy_o=1 -> ignored.
- Reset and early-out:
  - rst low during cycle 5 of DIV -> all outputs 0 immediately; after release, IDLE with busy_o=0.
  - With MDU_EARLY_OUT_EN, DIVU 3/10 -> hi=3, lo=0, valid_o 1 cycle after accept.
